// File: rtl/tl_burst_ram_responder_if.sv
// TileLink-UH A (request) and D (response) channel bundle seen by the burst RAM responder.
// The master side is the requesting client; the slave side is the RAM endpoint.
interface tl_burst_ram_responder_if;
    logic        auto_in_a_ready;
    logic        auto_in_a_valid;
    logic [2:0]  auto_in_a_bits_opcode;
    logic [2:0]  auto_in_a_bits_param;
    logic [3:0]  auto_in_a_bits_size;
    logic [7:0]  auto_in_a_bits_source;
    logic [30:0] auto_in_a_bits_address;
    logic [7:0]  auto_in_a_bits_mask;
    logic [63:0] auto_in_a_bits_data;
    logic        auto_in_a_bits_corrupt;
    logic        auto_in_d_ready;
    logic        auto_in_d_valid;
    logic [2:0]  auto_in_d_bits_opcode;
    logic [1:0]  auto_in_d_bits_param;
    logic [3:0]  auto_in_d_bits_size;
    logic [7:0]  auto_in_d_bits_source;
    logic        auto_in_d_bits_sink;
    logic        auto_in_d_bits_denied;
    logic [63:0] auto_in_d_bits_data;
    logic        auto_in_d_bits_corrupt;

    modport master (
        input  auto_in_a_ready,
        output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
               auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
        output auto_in_d_ready,
        input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
               auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink,
               auto_in_d_bits_denied, auto_in_d_bits_data, auto_in_d_bits_corrupt
    );

    modport slave (
        output auto_in_a_ready,
        input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
               auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
        input  auto_in_d_ready,
        output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
               auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink,
               auto_in_d_bits_denied, auto_in_d_bits_data, auto_in_d_bits_corrupt
    );
endinterface

// File: rtl/tl_burst_ram_responder.sv
// TileLink-UH manager endpoint backed by a 64-bit RAM: one transaction in flight,
// multi-beat Get/Put bursts, denied responses for out-of-range, oversize or unknown requests.
//
// state | meaning
// IDLE  | waiting for the first A beat of a request
// WR    | accepting the remaining beats of a Put burst
// RD    | returning AccessAckData beats of a Get
// ACK   | returning the single AccessAck of a Put
module tl_burst_ram_responder #(
    parameter logic [30:0] BASE_ADDR   = 31'h0800_0000,
    parameter int          DEPTH       = 512,
    parameter int          MAX_LG_SIZE = 6
) (
    input  logic                         clock,
    input  logic                         reset,
    tl_burst_ram_responder_if.slave      tl
);
    localparam int          AW    = $clog2(DEPTH);
    localparam int          CW    = (MAX_LG_SIZE > 3) ? MAX_LG_SIZE - 3 : 1;
    localparam logic [32:0] LIMIT = {2'b00, BASE_ADDR} + 33'(DEPTH * 8);

    typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   rem_q, rem_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [3:0]    size_q, size_d;
    logic [7:0]    source_q, source_d;
    logic          denied_q, denied_d;

    logic [63:0]   mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [AW-1:0] cur_idx;

    logic          a_fire, d_fire, req_get, req_denied;
    logic [AW-1:0] req_widx;
    logic [32:0]   req_end;
    logic [11:0]   req_rem;
    logic          unused_param;

    assign unused_param = ^tl.auto_in_a_bits_param;

    always_comb begin
        req_widx   = AW'((tl.auto_in_a_bits_address - BASE_ADDR) >> 3);
        req_end    = {2'b00, tl.auto_in_a_bits_address} + (33'd1 << tl.auto_in_a_bits_size);
        req_get    = (tl.auto_in_a_bits_opcode == 3'd4);
        req_denied = !(tl.auto_in_a_bits_opcode == 3'd0 || tl.auto_in_a_bits_opcode == 3'd1 || req_get)
                     || (tl.auto_in_a_bits_size > 4'(MAX_LG_SIZE))
                     || (tl.auto_in_a_bits_address < BASE_ADDR)
                     || (req_end > LIMIT);
        // rem counts beats still to go after the current one; oversize denied bursts need it wide
        req_rem    = (tl.auto_in_a_bits_size <= 4'd3) ? 12'd0
                     : 12'((13'd1 << (tl.auto_in_a_bits_size - 4'd3)) - 13'd1);
        cur_idx    = widx_q | AW'(cnt_q);
    end

    always_comb begin
        tl.auto_in_a_ready       = !reset && (state_q == IDLE || state_q == WR);
        tl.auto_in_d_valid       = (state_q == RD) || (state_q == ACK);
        tl.auto_in_d_bits_opcode = (state_q == RD) ? 3'd1 : 3'd0;
        tl.auto_in_d_bits_param  = 2'd0;
        tl.auto_in_d_bits_size   = size_q;
        tl.auto_in_d_bits_source = source_q;
        tl.auto_in_d_bits_sink   = 1'b0;
        tl.auto_in_d_bits_denied = denied_q;
        tl.auto_in_d_bits_data   = (state_q == RD && !denied_q) ? mem[cur_idx] : 64'd0;
        tl.auto_in_d_bits_corrupt = (state_q == RD) && denied_q;
    end

    assign a_fire = tl.auto_in_a_valid && tl.auto_in_a_ready;
    assign d_fire = tl.auto_in_d_valid && tl.auto_in_d_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        widx_d   = widx_q;
        size_d   = size_q;
        source_d = source_q;
        denied_d = denied_q;
        mem_we   = 1'b0;
        mem_widx = cur_idx;
        case (state_q)
            IDLE: begin
                if (a_fire) begin
                    size_d   = tl.auto_in_a_bits_size;
                    source_d = tl.auto_in_a_bits_source;
                    denied_d = req_denied;
                    widx_d   = req_widx;
                    cnt_d    = '0;
                    if (req_get) begin
                        rem_d   = req_rem;
                        state_d = RD;
                    end else begin
                        mem_we   = !req_denied && !tl.auto_in_a_bits_corrupt;
                        mem_widx = req_widx;
                        if (req_rem == 12'd0) begin
                            state_d = ACK;
                        end else begin
                            cnt_d   = CW'(1);
                            rem_d   = req_rem - 12'd1;
                            state_d = WR;
                        end
                    end
                end
            end
            WR: begin
                if (a_fire) begin
                    mem_we = !denied_q && !tl.auto_in_a_bits_corrupt;
                    cnt_d  = cnt_q + CW'(1);
                    if (rem_q == 12'd0) state_d = ACK;
                    else                rem_d   = rem_q - 12'd1;
                end
            end
            RD: begin
                if (d_fire) begin
                    cnt_d = cnt_q + CW'(1);
                    if (rem_q == 12'd0) state_d = IDLE;
                    else                rem_d   = rem_q - 12'd1;
                end
            end
            ACK: begin
                if (d_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            widx_q   <= '0;
            size_q   <= '0;
            source_q <= '0;
            denied_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            widx_q   <= widx_d;
            size_q   <= size_d;
            source_q <= source_d;
            denied_q <= denied_d;
        end
    end

    // RAM contents are deliberately left out of reset so data survives it
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (tl.auto_in_a_bits_mask[b]) mem[mem_widx][8*b +: 8] <= tl.auto_in_a_bits_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_tl_burst_ram_responder.sv
// Bench for tl_burst_ram_responder: directed vector table, hand-built burst/reset sequences,
// and randomized transactions checked against a word-array model of the RAM.
module tb_tl_burst_ram_responder;
   localparam logic [30:0] BASE  = 31'h0800_0000;
   localparam int          DEPTH = 512;
   localparam int          MAXLG = 6;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   tl_burst_ram_responder_if tl();

   tl_burst_ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .MAX_LG_SIZE(MAXLG)) dut (
      .clock(clock),
      .reset(reset),
      .tl(tl)
   );

   typedef struct {
      logic [2:0]  op;
      logic        den;
      logic        cor;
      logic [63:0] data;
      logic [3:0]  sz;
      logic [7:0]  src;
   } dbeat_t;

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  sz;
      logic [30:0] addr;
      logic [7:0]  mask;
      logic [63:0] data;
      logic        cor;
      logic [2:0]  e_op;
      logic        e_den;
      logic [63:0] e_data;
      int          e_beats;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   logic [63:0] model [DEPTH];
   logic [63:0] wq[$];
   dbeat_t      resp[$];
   vec_t        vt[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int nbeats(input logic [3:0] sz);
      return (sz <= 4'd3) ? 1 : (1 << (sz - 4'd3));
   endfunction

   function automatic logic model_denied(input logic [2:0] op, input logic [3:0] sz, input logic [30:0] addr);
      longint a   = longint'(addr);
      longint lo  = longint'(BASE);
      longint hi  = lo + DEPTH * 8;
      logic   bad = !(op == 3'd0 || op == 3'd1 || op == 3'd4);
      return bad || (int'(sz) > MAXLG) || (a < lo) || (a + (longint'(1) << sz) > hi);
   endfunction

   function automatic int word_of(input logic [30:0] addr);
      return int'((longint'(addr) - longint'(BASE)) / 8);
   endfunction

   task automatic model_put(input logic [3:0] sz, input logic [30:0] addr, input logic [7:0] mask,
                            input logic cor, input logic den);
      if (!den && !cor) begin
         for (int k = 0; k < nbeats(sz); k++) begin
            for (int b = 0; b < 8; b++)
               if (mask[b]) model[word_of(addr) + k][8*b +: 8] = wq[k][8*b +: 8];
         end
      end
   endtask

   task automatic send_beat(input logic [2:0] op, input logic [3:0] sz, input logic [7:0] src,
                            input logic [30:0] addr, input logic [7:0] mask, input logic [63:0] data,
                            input logic cor);
      int w = 0;
      tl.auto_in_a_valid        = 1'b1;
      tl.auto_in_a_bits_opcode  = op;
      tl.auto_in_a_bits_param   = 3'($urandom_range(0, 7));
      tl.auto_in_a_bits_size    = sz;
      tl.auto_in_a_bits_source  = src;
      tl.auto_in_a_bits_address = addr;
      tl.auto_in_a_bits_mask    = mask;
      tl.auto_in_a_bits_data    = data;
      tl.auto_in_a_bits_corrupt = cor;
      while (!tl.auto_in_a_ready && w < 50) begin
         @(posedge clock); @(negedge clock); w++;
      end
      if (!tl.auto_in_a_ready) check("a_ready timeout", 64'(tl.auto_in_a_ready), 64'd1);
      else begin
         @(posedge clock); @(negedge clock);
      end
      tl.auto_in_a_valid = 1'b0;
   endtask

   task automatic recv_beat(input int stall, output dbeat_t b, output int waited, output logic ok);
      waited = 0;
      tl.auto_in_d_ready = 1'b0;
      while (!tl.auto_in_d_valid && waited < 50) begin
         @(posedge clock); @(negedge clock); waited++;
      end
      ok = tl.auto_in_d_valid;
      b.op = tl.auto_in_d_bits_opcode;   b.den = tl.auto_in_d_bits_denied;
      b.cor = tl.auto_in_d_bits_corrupt; b.data = tl.auto_in_d_bits_data;
      b.sz = tl.auto_in_d_bits_size;     b.src = tl.auto_in_d_bits_source;
      if (!ok) begin
         check("d_valid timeout", 64'(ok), 64'd1);
         return;
      end
      for (int i = 0; i < stall; i++) begin
         @(posedge clock); @(negedge clock);
         check("d held valid", 64'(tl.auto_in_d_valid), 64'd1);
         check("d data stable", tl.auto_in_d_bits_data, b.data);
         check("d hdr stable", {tl.auto_in_d_bits_opcode, tl.auto_in_d_bits_denied, tl.auto_in_d_bits_size,
                                tl.auto_in_d_bits_source}, {b.op, b.den, b.sz, b.src});
      end
      tl.auto_in_d_ready = 1'b1;
      @(posedge clock); @(negedge clock);
      tl.auto_in_d_ready = 1'b0;
   endtask

   task automatic txn(input logic [2:0] op, input logic [3:0] sz, input logic [7:0] src,
                      input logic [30:0] addr, input logic [7:0] mask, input logic cor, input int stall);
      int     n;
      int     waited;
      logic   ok;
      dbeat_t b;
      resp.delete();
      if (op == 3'd4) begin
         send_beat(op, sz, src, addr, mask, 64'd0, cor);
         n = nbeats(sz);
      end else begin
         for (int k = 0; k < nbeats(sz); k++) send_beat(op, sz, src, addr, mask, wq[k], cor);
         n = 1;
      end
      for (int j = 0; j < n; j++) begin
         recv_beat(stall, b, waited, ok);
         if (!ok) break;
         check("D beat latency", 64'(waited), 64'd0);
         resp.push_back(b);
      end
   endtask

   task automatic do_checked(input logic [2:0] op, input logic [3:0] sz, input logic [7:0] src,
                             input logic [30:0] addr, input logic [7:0] mask, input logic cor,
                             input int stall, input string tag);
      logic        den = model_denied(op, sz, addr);
      logic [63:0] exp[$];
      if (op != 3'd4) begin
         model_put(sz, addr, mask, cor, den);
         exp.push_back(64'd0);
      end else begin
         for (int k = 0; k < nbeats(sz); k++) exp.push_back(den ? 64'd0 : model[word_of(addr) + k]);
      end
      txn(op, sz, src, addr, mask, cor, stall);
      check({tag, " beats"}, 64'(resp.size()), 64'(exp.size()));
      for (int j = 0; j < resp.size() && j < exp.size(); j++) begin
         check({tag, " opcode"}, 64'(resp[j].op), (op == 3'd4) ? 64'd1 : 64'd0);
         check({tag, " denied"}, 64'(resp[j].den), 64'(den));
         check({tag, " corrupt"}, 64'(resp[j].cor), 64'(den && op == 3'd4));
         check({tag, " data"}, resp[j].data, exp[j]);
         check({tag, " size/source"}, {resp[j].sz, resp[j].src}, {sz, src});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] others[5];
      others = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
      tl.auto_in_a_valid = 1'b0; tl.auto_in_a_bits_opcode = '0; tl.auto_in_a_bits_param = '0;
      tl.auto_in_a_bits_size = '0; tl.auto_in_a_bits_source = '0; tl.auto_in_a_bits_address = '0;
      tl.auto_in_a_bits_mask = '0; tl.auto_in_a_bits_data = '0; tl.auto_in_a_bits_corrupt = 1'b0;
      tl.auto_in_d_ready = 1'b0;

      @(negedge clock); @(negedge clock);
      check("reset a_ready", 64'(tl.auto_in_a_ready), 64'd0);
      check("reset d_valid", 64'(tl.auto_in_d_valid), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      check("idle a_ready", 64'(tl.auto_in_a_ready), 64'd1);
      check("idle d_valid", 64'(tl.auto_in_d_valid), 64'd0);
      check("reset size/source/denied", {tl.auto_in_d_bits_size, tl.auto_in_d_bits_source,
                                         tl.auto_in_d_bits_denied}, 64'd0);

      // known RAM image: word i = C0DE_0000_0000_0000 | i, written as 64B bursts
      for (int blk = 0; blk < DEPTH / 8; blk++) begin
         wq.delete();
         for (int k = 0; k < 8; k++) wq.push_back(64'hC0DE_0000_0000_0000 | 64'(blk * 8 + k));
         do_checked(3'd0, 4'd6, 8'(blk), BASE + 31'(blk * 64), 8'hFF, 1'b0, 0, "init");
      end

      vt.push_back('{3'd0, 4'd3, 31'h0800_0000, 8'hFF, 64'h1122334455667788, 1'b0, 3'd0, 1'b0, 64'd0, 1});
      vt.push_back('{3'd4, 4'd3, 31'h0800_0000, 8'h00, 64'd0, 1'b0, 3'd1, 1'b0, 64'h1122334455667788, 1});
      vt.push_back('{3'd0, 4'd3, 31'h0800_0008, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 3'd0, 1'b0, 64'd0, 1});
      vt.push_back('{3'd1, 4'd3, 31'h0800_0008, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 1'b0, 64'd0, 1});
      vt.push_back('{3'd4, 4'd3, 31'h0800_0008, 8'h00, 64'd0, 1'b0, 3'd1, 1'b0, 64'hAAAA_AAAA_FFFF_FFFF, 1});
      vt.push_back('{3'd4, 4'd3, 31'h0800_1000, 8'h00, 64'd0, 1'b0, 3'd1, 1'b1, 64'd0, 1});
      vt.push_back('{3'd4, 4'd7, 31'h0800_0000, 8'h00, 64'd0, 1'b0, 3'd1, 1'b1, 64'd0, 16});
      vt.push_back('{3'd2, 4'd3, 31'h0800_0000, 8'hFF, 64'd0, 1'b0, 3'd0, 1'b1, 64'd0, 1});
      vt.push_back('{3'd4, 4'd3, 31'h0800_0000, 8'h00, 64'd0, 1'b0, 3'd1, 1'b0, 64'h1122334455667788, 1});
      vt.push_back('{3'd4, 4'd3, 31'h07FF_FFF8, 8'h00, 64'd0, 1'b0, 3'd1, 1'b1, 64'd0, 1});
      vt.push_back('{3'd0, 4'd2, 31'h0800_0010, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 3'd0, 1'b0, 64'd0, 1});
      vt.push_back('{3'd0, 4'd3, 31'h0800_0010, 8'hFF, 64'd0, 1'b1, 3'd0, 1'b0, 64'd0, 1});
      vt.push_back('{3'd4, 4'd3, 31'h0800_0010, 8'h00, 64'd0, 1'b0, 3'd1, 1'b0, 64'h0123456789ABCDEF, 1});
      vt.push_back('{3'd4, 4'd3, 31'h0800_0FF8, 8'h00, 64'd0, 1'b0, 3'd1, 1'b0, 64'hC0DE_0000_0000_01FF, 1});
      vt.push_back('{3'd0, 4'd6, 31'h0800_0FE0, 8'hFF, 64'd0, 1'b0, 3'd0, 1'b1, 64'd0, 1});
      vt.push_back('{3'd4, 4'd3, 31'h0800_0FF8, 8'h00, 64'd0, 1'b0, 3'd1, 1'b0, 64'hC0DE_0000_0000_01FF, 1});

      for (int i = 0; i < vt.size(); i++) begin
         wq.delete();
         for (int k = 0; k < nbeats(vt[i].sz); k++) wq.push_back(vt[i].data);
         if (vt[i].op != 3'd4) model_put(vt[i].sz, vt[i].addr, vt[i].mask, vt[i].cor, vt[i].e_den);
         txn(vt[i].op, vt[i].sz, 8'(i + 16), vt[i].addr, vt[i].mask, vt[i].cor, 0);
         check($sformatf("vec%0d beats", i), 64'(resp.size()), 64'(vt[i].e_beats));
         for (int j = 0; j < resp.size(); j++) begin
            check($sformatf("vec%0d opcode", i), 64'(resp[j].op), 64'(vt[i].e_op));
            check($sformatf("vec%0d denied", i), 64'(resp[j].den), 64'(vt[i].e_den));
            check($sformatf("vec%0d corrupt", i), 64'(resp[j].cor), 64'(vt[i].e_den && vt[i].e_op == 3'd1));
            check($sformatf("vec%0d data", i), resp[j].data, vt[i].e_data);
            check($sformatf("vec%0d size/source", i), {resp[j].sz, resp[j].src}, {vt[i].sz, 8'(i + 16)});
         end
      end

      // 64B burst with a stalled AccessAck, then read back in order
      wq.delete();
      for (int k = 0; k < 8; k++) wq.push_back(64'(k));
      do_checked(3'd0, 4'd6, 8'h33, BASE + 31'h40, 8'hFF, 1'b0, 5, "burst put");
      do_checked(3'd4, 4'd6, 8'h5A, BASE + 31'h40, 8'h00, 1'b0, 1, "burst get");
      for (int k = 0; k < resp.size(); k++) check("burst order", resp[k].data, 64'(k));

      // reset while the third beat of an 8-beat Get is on D
      begin
         dbeat_t b;
         int     w;
         logic   ok;
         send_beat(3'd4, 4'd6, 8'h77, BASE + 31'h40, 8'h00, 64'd0, 1'b0);
         recv_beat(0, b, w, ok);
         recv_beat(0, b, w, ok);
         check("mid-get beat2 valid", 64'(tl.auto_in_d_valid), 64'd1);
         check("mid-get beat2 data", tl.auto_in_d_bits_data, 64'd2);
         reset = 1'b1;
         #1;
         check("async reset d_valid", 64'(tl.auto_in_d_valid), 64'd0);
         check("async reset a_ready", 64'(tl.auto_in_a_ready), 64'd0);
         @(negedge clock);
         reset = 1'b0;
         #1;
         check("post-reset a_ready", 64'(tl.auto_in_a_ready), 64'd1);
         @(negedge clock);
         for (int i = 0; i < 3; i++) begin
            check("no stale beat", 64'(tl.auto_in_d_valid), 64'd0);
            @(negedge clock);
         end
         do_checked(3'd4, 4'd3, 8'h78, BASE + 31'h48, 8'h00, 1'b0, 0, "post-reset get");
      end

      for (int t = 0; t < 60; t++) begin
         int          r   = int'($urandom_range(0, 7));
         logic [2:0]  op  = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 7) ? 3'd4 : others[$urandom_range(0, 4)];
         logic [3:0]  sz  = 4'($urandom_range(0, 7));
         longint      a   = longint'(BASE) + longint'(int'($urandom_range(0, DEPTH * 8 + 127)) - 64);
         logic [30:0] adr;
         a   = a & ~((longint'(1) << sz) - 1);
         adr = 31'(a);
         wq.delete();
         for (int k = 0; k < nbeats(sz); k++) wq.push_back({$urandom, $urandom});
         do_checked(op, sz, 8'($urandom_range(0, 255)), adr, 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)), $sformatf("rand%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
